// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: one outstanding imem request, registered
// instruction to decode, branch-aware next-PC, sticky halt on fetch timeout.
module fetch_unit #(
    parameter int unsigned        ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              BrTaken,
    input  logic              UncondBr,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] next_pc;

    assign imem_addr = pc;

    // Branch offsets are word offsets, so append two zero bits after sign extension.
    always_comb begin
        offset = '0;
        if (UncondBr)
            offset = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
        else
            offset = {{(ADDR_W-21){instr[23]}}, instr[23:5], 2'b00};
        next_pc = BrTaken ? (pc + offset) : (pc + ADDR_W'(4));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    cnt      <= '0;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        cnt         <= '0;
                        state       <= ISSUE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= HALT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        cnt         <= '0;
                        state       <= FETCH;
                    end
                end
                HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: state <= HALT;
            endcase
        end
    end

    a_br_known: assert property (@(posedge clk) disable iff (!reset)
        exec_done |-> !$isunknown({BrTaken, UncondBr}));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard queues hold expected instructions
// and next-PC values, compared when the unit produces them.
module tb_fetch_unit;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        BrTaken;
    logic        UncondBr;
    logic [63:0] pc;
    logic        fetch_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] instr_q[$];
    logic [63:0] pc_q[$];
    logic [63:0] exp_pc;
    logic [31:0] last_instr;

    fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .BrTaken    (BrTaken),
        .UncondBr   (UncondBr),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_next(input logic [63:0] p, input logic [31:0] ins,
                                               input logic br, input logic unc);
        logic signed [25:0] s26;
        logic signed [18:0] s19;
        longint off;
        s26 = ins[25:0];
        s19 = ins[23:5];
        if (!br) return p + 64'd4;
        off = unc ? longint'(s26) * 4 : longint'(s19) * 4;
        return p + 64'(off);
    endfunction

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", 64'(imem_req), 64'd1);
    endtask

    // Memory answers one cycle after it sees the request.
    task automatic do_fetch(input logic [31:0] data);
        wait_req();
        check("imem_addr", imem_addr, exp_pc);
        @(negedge clk);
        check("req_held", 64'(imem_req), 64'd1);
        imem_ack   = 1'b1;
        imem_rdata = data;
        instr_q.push_back(data);
        last_instr = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("valid_after_ack", 64'(instr_valid), 64'd1);
        check("req_low_issue", 64'(imem_req), 64'd0);
        if (instr_q.size() == 0) check("instr_q_empty", 64'd1, 64'd0);
        else check("instr", 64'(instr), 64'(instr_q.pop_front()));
    endtask

    task automatic execute(input logic br, input logic unc);
        pc_q.push_back(model_next(exp_pc, last_instr, br, unc));
        exec_done = 1'b1;
        BrTaken   = br;
        UncondBr  = unc;
        @(negedge clk);
        exec_done = 1'b0;
        BrTaken   = 1'b0;
        UncondBr  = 1'b0;
        check("req_after_exec", 64'(imem_req), 64'd1);
        check("valid_after_exec", 64'(instr_valid), 64'd0);
        if (pc_q.size() == 0) check("pc_q_empty", 64'd1, 64'd0);
        else begin
            exp_pc = pc_q.pop_front();
            check("next_pc", pc, exp_pc);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("idle_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        check("req_rise", 64'(imem_req), 64'd1);
        exp_pc = 64'h0;
    endtask

    initial begin
        int k;
        logic [31:0] held;
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        exec_done = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0;
        exp_pc = 64'h0; last_instr = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 64'h0);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_err", 64'(fetch_err), 64'd0);

        release_reset();
        do_fetch(32'h91000421);
        execute(1'b0, 1'b0);                           // 0x4
        do_fetch({6'b000101, 26'd15});      execute(1'b1, 1'b1);   // 0x40
        do_fetch({6'b000101, 26'h3FFFFFE}); execute(1'b1, 1'b1);   // 0x38
        do_fetch({6'b000101, 26'd50});      execute(1'b1, 1'b1);   // 0x100
        do_fetch({8'hB4, 19'd3, 5'd0});     execute(1'b1, 1'b0);   // 0x10C
        do_fetch({6'b000101, 26'h3FFFFFD}); execute(1'b1, 1'b1);   // 0x100
        do_fetch({8'hB4, 19'd3, 5'd0});     execute(1'b0, 1'b0);   // 0x104
        do_fetch({6'b000101, 26'h3FFFFBE}); execute(1'b1, 1'b1);   // 0xFF..FC
        check("pc_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);

        held = 32'hD503201F;
        do_fetch(held);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
            end
            @(negedge clk);
            imem_ack = 1'b0;
            check("stall_instr", 64'(instr), 64'(held));
            check("stall_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
            check("stall_req", 64'(imem_req), 64'd0);
            check("stall_valid", 64'(instr_valid), 64'd1);
        end
        execute(1'b0, 1'b0);
        check("wrap_pc", pc, 64'h0);

        k = 0;
        while (fetch_err !== 1'b1 && k < int'(TMO) + 8) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", 64'(k), 64'(TMO));
        check("halt_req", 64'(imem_req), 64'd0);
        exec_done = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h12345678;
        repeat (3) @(negedge clk);
        exec_done = 1'b0; imem_ack = 1'b0;
        check("halt_err", 64'(fetch_err), 64'd1);
        check("halt_req2", 64'(imem_req), 64'd0);
        check("halt_valid", 64'(instr_valid), 64'd0);
        check("halt_pc", pc, 64'h0);

        reset = 1'b0;
        #1;
        check("rst2_err", 64'(fetch_err), 64'd0);
        check("rst2_pc", pc, 64'h0);
        release_reset();
        do_fetch(32'h91000421);
        execute(1'b0, 1'b0);                           // 0x4, now in FETCH
        imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
        reset = 1'b0;
        #1;
        check("rst3_req", 64'(imem_req), 64'd0);
        check("rst3_pc", pc, 64'h0);
        check("rst3_valid", 64'(instr_valid), 64'd0);
        @(posedge clk);
        #1 imem_ack = 1'b0;
        check("rst3_valid2", 64'(instr_valid), 64'd0);
        release_reset();
        do_fetch(32'h8B020020);
        execute(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
